pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Hazard and stall controller for the 5-stage RISC-V pipeline. It drives the enable and flush controls of the PC, IF/ID, ID/EX and EX/MEM registers. It resolves three conditions: load-use hazards (one-bubble stall), taken branches resolved in EX (two-instruction flush), and multi-cycle EX operations (full front-end freeze with a watchdog). It also keeps stall and flush event counters for performance debug.

## Interface
- MC_MAX, 64: maximum MC_WAIT cycles before the watchdog fires; legal range 2..1024.
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all state and counters.
- id_rs1, id_rs2  in  5 each  source register indices of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1 each  the ID instruction actually reads rs1/rs2.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_mem_read  in  1  the EX instruction is a load.
- branch_taken  in  1  the EX instruction redirects the PC this cycle.
- ex_mc_start  in  1  the EX instruction starts a multi-cycle operation.
- ex_mc_done  in  1  the multi-cycle unit's result is valid this cycle.
- pc_en, if_id_en, id_ex_en  out  1 each  register update enables.
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  load a bubble (all-zero) into the register.
- busy  out  1  FSM is in MC_WAIT.
- mc_timeout  out  1  sticky; the watchdog has fired since reset.
- stall_cycles  out  32  count of cycles with pc_en=0.
- flush_count  out  32  count of branch-flush cycles.

## Operation
- FSM states: RUN, MC_WAIT. Reset state: RUN.
- Control outputs are combinational from state and inputs (Mealy). Default in RUN: all enables 1, all flushes 0.
- Priority in RUN, highest first: branch_taken > ex_mc_start > load-use.
- Branch (RUN, branch_taken=1):
  - if_id_flush=1, id_ex_flush=1; pc_en=1.
  - flush_count increments.
  - ex_mc_start and load-use are ignored that cycle.
- MC start (RUN, ex_mc_start=1, branch_taken=0):
  - pc_en=if_id_en=id_ex_en=0, ex_mem_flush=1.
  - Next state MC_WAIT; wait_cnt cleared to 0.
  - ex_mc_done is ignored in RUN, so the minimum freeze is 2 cycles.
- MC_WAIT, ex_mc_done=0 and wait_cnt<MC_MAX-1:
  - Same freeze outputs as the start cycle.
  - wait_cnt increments.
  - branch_taken and load-use are ignored.
- MC_WAIT, ex_mc_done=1:
  - Defaults (release); next state RUN.
- MC_WAIT, ex_mc_done=0 and wait_cnt==MC_MAX-1:
  - Watchdog: release as for done, mc_timeout set, next state RUN.
- Load-use (RUN, no branch, no mc_start) asserts when:
  - ex_mem_read=1, ex_rd!=0, and ((id_uses_rs1 and id_rs1==ex_rd) or (id_uses_rs2 and id_rs2==ex_rd)).
  - Response: pc_en=0, if_id_en=0, id_ex_flush=1; id_ex_en stays 1.
- x0 never causes a hazard.
- stall_cycles increments in every cycle with pc_en=0. Both counters wrap modulo 2^32.
- busy=1 exactly when the state is MC_WAIT.

## Timing
- After reset: state RUN, wait_cnt 0, mc_timeout 0, stall_cycles 0, flush_count 0.
- Combinational outputs take RUN defaults with all inputs low.
- Zero-cycle latency from inputs to control outputs; state and counters update on the next edge.
- Load-use costs exactly 1 stall cycle. The load advances to MEM, so the hazard clears by itself.
- Branch costs 2 killed instructions and 0 stall cycles.
- MC operation with done seen N cycles after start (N≥1):
  - Freeze cycles = N, then the release cycle.
  - stall_cycles += N.
- Watchdog: the freeze lasts MC_MAX cycles including the start cycle.
- Reset asserted mid-MC_WAIT: next state RUN, counters 0. Outputs return to RUN defaults in the cycle after the reset edge.
- reset asserted wins over all events in the same cycle. No counter increments on a reset edge.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 for one cycle -> pc_en=0, if_id_en=0, id_ex_flush=1 that cycle; stall_cycles=1 after; ex_rd=0 with the same inputs -> no stall.
- Branch: branch_taken=1 with a simultaneous load-use and ex_mc_start -> if_id_flush=id_ex_flush=1, pc_en=1, busy stays 0, flush_count=1.
- MC op: ex_mc_start at cycle 0, ex_mc_done at cycle 3 -> freeze on cycles 0-2, release at 3, busy=1 on cycles 1-3, stall_cycles=3.
- Watchdog: MC_MAX=4, ex_mc_start, done never asserted -> freeze on cycles 0-3, release with mc_timeout=1 after cycle 3; mc_timeout remains 1 through later done pulses.
- Reset mid-wait: reset during MC_WAIT -> busy=0, mc_timeout=0, counters 0 on the next cycle.
- Counter wrap: force stall_cycles near 2^32-1 via a long wait -> wraps to 0, no other side effect.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall controller for the 5-stage pipeline: load-use bubbles, branch flushes,
// multi-cycle EX freezes with a watchdog, plus stall/flush event counters.
module pipe_hazard_ctrl #(
    parameter int MC_MAX = 64
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [4:0]  i_id_rs1,
    input  logic [4:0]  i_id_rs2,
    input  logic        i_id_uses_rs1,
    input  logic        i_id_uses_rs2,
    input  logic [4:0]  i_ex_rd,
    input  logic        i_ex_mem_read,
    input  logic        i_branch_taken,
    input  logic        i_ex_mc_start,
    input  logic        i_ex_mc_done,
    output logic        o_pc_en,
    output logic        o_if_id_en,
    output logic        o_id_ex_en,
    output logic        o_if_id_flush,
    output logic        o_id_ex_flush,
    output logic        o_ex_mem_flush,
    output logic        o_busy,
    output logic        o_mc_timeout,
    output logic [31:0] o_stall_cycles,
    output logic [31:0] o_flush_count
);

    localparam int CW = (MC_MAX > 2) ? $clog2(MC_MAX) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(MC_MAX - 1);

    typedef enum logic {
        RUN,
        MC_WAIT
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_wait_cnt;
    logic          r_mc_timeout;
    logic [31:0]   r_stall_cycles;
    logic [31:0]   r_flush_count;

    logic w_load_use;
    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_wd_fire;

    // Register x0 is hard-wired to zero, so a load targeting it never creates a dependency.
    assign w_rs1_hit  = i_id_uses_rs1 && (i_id_rs1 == i_ex_rd);
    assign w_rs2_hit  = i_id_uses_rs2 && (i_id_rs2 == i_ex_rd);
    assign w_load_use = i_ex_mem_read && (i_ex_rd != 5'd0) && (w_rs1_hit || w_rs2_hit);
    assign w_wd_fire  = (r_state == MC_WAIT) && !i_ex_mc_done && (r_wait_cnt == WAIT_LAST);

    always_comb begin
        o_pc_en        = 1'b1;
        o_if_id_en     = 1'b1;
        o_id_ex_en     = 1'b1;
        o_if_id_flush  = 1'b0;
        o_id_ex_flush  = 1'b0;
        o_ex_mem_flush = 1'b0;
        case (r_state)
            RUN: begin
                if (i_branch_taken) begin
                    o_if_id_flush = 1'b1;
                    o_id_ex_flush = 1'b1;
                end else if (i_ex_mc_start) begin
                    o_pc_en        = 1'b0;
                    o_if_id_en     = 1'b0;
                    o_id_ex_en     = 1'b0;
                    o_ex_mem_flush = 1'b1;
                end else if (w_load_use) begin
                    o_pc_en       = 1'b0;
                    o_if_id_en    = 1'b0;
                    o_id_ex_flush = 1'b1;
                end
            end
            MC_WAIT: begin
                if (!i_ex_mc_done && !w_wd_fire) begin
                    o_pc_en        = 1'b0;
                    o_if_id_en     = 1'b0;
                    o_id_ex_en     = 1'b0;
                    o_ex_mem_flush = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= RUN;
            r_wait_cnt     <= '0;
            r_mc_timeout   <= 1'b0;
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (!o_pc_en)
                r_stall_cycles <= r_stall_cycles + 32'd1;
            case (r_state)
                RUN: begin
                    if (i_branch_taken) begin
                        r_flush_count <= r_flush_count + 32'd1;
                    end else if (i_ex_mc_start) begin
                        r_state    <= MC_WAIT;
                        r_wait_cnt <= '0;
                    end
                end
                MC_WAIT: begin
                    if (i_ex_mc_done) begin
                        r_state <= RUN;
                    end else if (w_wd_fire) begin
                        r_state      <= RUN;
                        r_mc_timeout <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

    assign o_busy         = (r_state == MC_WAIT);
    assign o_mc_timeout   = r_mc_timeout;
    assign o_stall_cycles = r_stall_cycles;
    assign o_flush_count  = r_flush_count;

endmodule
